wtc_7seg_cmd_arb: RTL and testbench

//  - Shares the single 7-seg command port (3b mode + 5b value) between NUM_REQ requesters.
//  - Examples of requesters: counter display, button UI, brightness control.
//  - After reset it runs a start-up sequence: RESET, then set brightness divisor.
//  - Then it round-robin arbitrates commands, enforcing GAP_CYCLES NOP cycles between issues.
//  - Sits between the application logic and the 7-seg control block; its outputs drive i_mode/i_value directly.

---
 rtl/wtc_7seg_pkg.sv | 17 +
 rtl/wtc_rr_arbiter.sv | 34 +++
 rtl/wtc_7seg_cmd_arb.sv | 167 ++++++++++++++++
 tb/tb_wtc_7seg_cmd_arb.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/wtc_7seg_pkg.sv
// Shared encodings for the 7-seg command arbiter: command modes and FSM states.
// The optional lock feature in the top is enabled with WTC_7SEG_ARB_LOCK_EN.
package wtc_7seg_pkg;

  localparam logic [2:0] MODE_SET    = 3'b000;
  localparam logic [2:0] MODE_RST    = 3'b001;
  localparam logic [2:0] MODE_NOP    = 3'b100;
  localparam logic [2:0] MODE_PERIOD = 3'b111;

  typedef enum logic [1:0] {
    ST_INIT_RST = 2'd0,
    ST_INIT_BRT = 2'd1,
    ST_IDLE     = 2'd2,
    ST_GAP      = 2'd3
  } arb_state_e;

endpackage

// File: rtl/wtc_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping around, reported as a one-hot grant plus its index.
module wtc_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [2:0]         ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [2:0]         idx_o,
  output logic               found_o
);

  int   cand;
  logic hit;

  // Scan candidates in priority order; the first hit masks all later ones.
  always_comb begin
    grant_o = '0;
    idx_o   = 3'd0;
    found_o = 1'b0;
    cand    = 0;
    hit     = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = (int'(ptr_i) + off) % NUM_REQ;
      for (int k = 0; k < NUM_REQ; k++) begin
        hit        = (k == cand) && req_i[k] && !found_o;
        grant_o[k] = grant_o[k] | hit;
        idx_o      = hit ? 3'(k) : idx_o;
        found_o    = found_o | hit;
      end
    end
  end

endmodule

// File: rtl/wtc_7seg_cmd_arb.sv
// Shares the 7-seg command port between NUM_REQ requesters: start-up sequence,
// round-robin issue with NOP gaps; WTC_7SEG_ARB_LOCK_EN adds burst locking.
module wtc_7seg_cmd_arb
  import wtc_7seg_pkg::*;
#(
  parameter int         NUM_REQ     = 2,
  parameter int         GAP_CYCLES  = 0,
  parameter logic [4:0] INIT_BRIGHT = 5'd4,
  parameter int         MAX_BURST   = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [3*NUM_REQ-1:0]   i_req_mode,
  input  logic [5*NUM_REQ-1:0]   i_req_value,
`ifdef WTC_7SEG_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]     i_req_lock,
`endif
  output logic [NUM_REQ-1:0]     o_req_ready,
  output logic [2:0]             o_mode,
  output logic [4:0]             o_value,
  output logic [2:0]             o_grant_id,
  output logic                   o_busy
);

  arb_state_e         state_q;
  logic [2:0]         ptr_q, ptr_d, ptr_inc;
  logic [7:0]         gap_q;
  logic [2:0]         mode_q;
  logic [4:0]         value_q;
  logic [2:0]         grant_id_q;
  logic               busy_q;

  logic [NUM_REQ-1:0] win_grant;
  logic [2:0]         win_idx;
  logic               win_found;
  logic [2:0]         win_mode;
  logic [4:0]         win_value;
  logic               xfer;

  wtc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i   (i_req_valid),
    .ptr_i   (ptr_q),
    .grant_o (win_grant),
    .idx_o   (win_idx),
    .found_o (win_found)
  );

  assign o_req_ready = (state_q == ST_IDLE) ? win_grant : '0;
  assign xfer        = (state_q == ST_IDLE) && win_found;

  // Select the winner's command by masking with the one-hot grant.
  always_comb begin
    win_mode  = 3'd0;
    win_value = 5'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      win_mode  = win_mode  | ({3{win_grant[k]}} & i_req_mode[3*k +: 3]);
      win_value = win_value | ({5{win_grant[k]}} & i_req_value[5*k +: 5]);
    end
    ptr_inc = (int'(win_idx) + 1 >= NUM_REQ) ? 3'd0 : win_idx + 3'd1;
  end

`ifdef WTC_7SEG_ARB_LOCK_EN
  logic [3:0] burst_q, burst_d, burst_eff;
  logic       win_lock, keep;

  // A locked winner keeps the pointer until its burst budget runs out; a
  // grant to anyone other than the pointer holder starts a fresh count.
  always_comb begin
    win_lock = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      win_lock = win_lock | (win_grant[k] & i_req_lock[k]);
    end
    burst_eff = (win_idx == ptr_q) ? burst_q : 4'd0;
    keep      = win_lock && (int'(burst_eff) + 1 < MAX_BURST);
    ptr_d     = keep ? win_idx : ptr_inc;
    if (state_q == ST_IDLE) begin
      burst_d = (xfer && keep) ? burst_eff + 4'd1 : 4'd0;
    end else begin
      burst_d = burst_q;
    end
  end

  // Burst counter register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      burst_q <= 4'd0;
    end else begin
      burst_q <= burst_d;
    end
  end
`else
  assign ptr_d = ptr_inc;
`endif

  // Arbiter FSM with registered command bus, grant id and busy flag.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= ST_INIT_RST;
      ptr_q      <= 3'd0;
      gap_q      <= 8'd0;
      mode_q     <= MODE_NOP;
      value_q    <= 5'd0;
      grant_id_q <= 3'd0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT_RST: begin
          mode_q  <= MODE_RST;
          value_q <= 5'd0;
          busy_q  <= 1'b1;
          state_q <= ST_INIT_BRT;
        end
        ST_INIT_BRT: begin
          mode_q  <= MODE_PERIOD;
          value_q <= INIT_BRIGHT;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (xfer) begin
            mode_q     <= win_mode;
            value_q    <= win_value;
            grant_id_q <= win_idx;
            ptr_q      <= ptr_d;
            if (GAP_CYCLES > 0) begin
              state_q <= ST_GAP;
              gap_q   <= 8'(GAP_CYCLES);
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            mode_q  <= MODE_NOP;
            value_q <= 5'd0;
            busy_q  <= 1'b0;
          end
        end
        ST_GAP: begin
          mode_q  <= MODE_NOP;
          value_q <= 5'd0;
          if (gap_q <= 8'd1) begin
            gap_q   <= 8'd0;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q  <= gap_q - 8'd1;
            busy_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_INIT_RST;
          mode_q  <= MODE_NOP;
          value_q <= 5'd0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign o_mode     = mode_q;
  assign o_value    = value_q;
  assign o_grant_id = grant_id_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_wtc_7seg_cmd_arb.sv
// Bench for wtc_7seg_cmd_arb: two instances (2 req / no gap, 3 req / gap 3)
// checked cycle by cycle against a queue-free behavioural model of the arbiter.
module tb_wtc_7seg_cmd_arb;

  localparam int NA = 2;
  localparam int NB = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NA-1:0]   va, ra;
  logic [3*NA-1:0] ma;
  logic [5*NA-1:0] xa;
  logic [2:0]      mode_a, gid_a;
  logic [4:0]      val_a;
  logic            busy_a;
  logic [NB-1:0]   vb, rb;
  logic [3*NB-1:0] mb;
  logic [5*NB-1:0] xb;
  logic [2:0]      mode_b, gid_b;
  logic [4:0]      val_b;
  logic            busy_b;

  // Requester state per instance d and requester k.
  logic       rv [2][3];
  logic [2:0] rm [2][3];
  logic [4:0] rx [2][3];

  always_comb begin
    for (int k = 0; k < NA; k++) begin
      va[k] = rv[0][k]; ma[3*k +: 3] = rm[0][k]; xa[5*k +: 5] = rx[0][k];
    end
    for (int k = 0; k < NB; k++) begin
      vb[k] = rv[1][k]; mb[3*k +: 3] = rm[1][k]; xb[5*k +: 5] = rx[1][k];
    end
  end

`ifdef WTC_7SEG_ARB_LOCK_EN
  logic [NA-1:0] lock_a = '0;
  logic [NB-1:0] lock_b = '0;
`endif

  wtc_7seg_cmd_arb #(.NUM_REQ(NA), .GAP_CYCLES(0), .INIT_BRIGHT(5'd4)) dut_a (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_req_valid(va), .i_req_mode(ma), .i_req_value(xa),
`ifdef WTC_7SEG_ARB_LOCK_EN
    .i_req_lock(lock_a),
`endif
    .o_req_ready(ra), .o_mode(mode_a), .o_value(val_a), .o_grant_id(gid_a), .o_busy(busy_a)
  );

  wtc_7seg_cmd_arb #(.NUM_REQ(NB), .GAP_CYCLES(3), .INIT_BRIGHT(5'd9)) dut_b (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_req_valid(vb), .i_req_mode(mb), .i_req_value(xb),
`ifdef WTC_7SEG_ARB_LOCK_EN
    .i_req_lock(lock_b),
`endif
    .o_req_ready(rb), .o_mode(mode_b), .o_value(val_b), .o_grant_id(gid_b), .o_busy(busy_b)
  );

  int tests_run = 0;
  int tests_failed = 0;
  bit rand_on = 1'b0;

  // Reference model: rotation pointer, remaining NOP cycles, edges since reset release.
  int         ptr[2], cool[2], edges[2];
  int         nreq[2]   = '{2, 3};
  int         gapc[2]   = '{0, 3};
  logic [4:0] bright[2] = '{5'd4, 5'd9};
  logic [2:0] e_mode[2], e_gid[2];
  logic [4:0] e_val[2];
  bit         e_cmd[2], e_busy[2];
  bit         acc[2][3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input int d);
    for (int off = 0; off < nreq[d]; off++) begin
      if (rv[d][(ptr[d] + off) % nreq[d]]) return (ptr[d] + off) % nreq[d];
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ptr[d] = 0; cool[d] = 0; edges[d] = 0;
    end
  endtask

  // One clock: check ready before the edge, predict the edge, check outputs after it.
  task automatic step();
    int w;
    logic [2:0] er, ar;
    #1;
    for (int d = 0; d < 2; d++) begin
      w  = winner(d);
      er = (edges[d] >= 2 && cool[d] == 0 && w >= 0) ? 3'(1 << w) : 3'd0;
      ar = (d == 0) ? {1'b0, ra} : rb;
      check($sformatf("ready_%0d", d), ar, er);
      e_cmd[d] = 1'b0;
      for (int k = 0; k < 3; k++) acc[d][k] = 1'b0;
      if (edges[d] == 0) begin
        e_mode[d] = 3'b001; e_val[d] = 5'd0;
      end else if (edges[d] == 1) begin
        e_mode[d] = 3'b111; e_val[d] = bright[d];
      end else if (cool[d] > 0) begin
        cool[d]--; e_mode[d] = 3'b100;
      end else if (w >= 0) begin
        e_mode[d] = rm[d][w]; e_val[d] = rx[d][w]; e_gid[d] = 3'(w);
        e_cmd[d] = 1'b1; acc[d][w] = 1'b1;
        ptr[d] = (w + 1) % nreq[d]; cool[d] = gapc[d];
      end else begin
        e_mode[d] = 3'b100;
      end
      edges[d]++;
      e_busy[d] = (edges[d] < 2) || (cool[d] > 0);
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("mode_%0d", d), (d == 0) ? mode_a : mode_b, e_mode[d]);
      if (e_mode[d] != 3'b100 || e_cmd[d])
        check($sformatf("value_%0d", d), (d == 0) ? val_a : val_b, e_val[d]);
      if (e_cmd[d])
        check($sformatf("grant_id_%0d", d), (d == 0) ? gid_a : gid_b, e_gid[d]);
      check($sformatf("busy_%0d", d), (d == 0) ? busy_a : busy_b, e_busy[d]);
    end
    if (rand_on) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < nreq[d]; k++) begin
          if (acc[d][k] || !rv[d][k]) begin
            rv[d][k] = ($urandom_range(0, 1) == 1);
            rm[d][k] = 3'($urandom);
            rx[d][k] = 5'($urandom);
          end else if ($urandom_range(0, 7) == 0) begin
            rv[d][k] = 1'b0;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 3; k++) begin
        rv[d][k] = 1'b0; rm[d][k] = 3'd0; rx[d][k] = 5'd0; acc[d][k] = 1'b0;
      end
    #2 rst_n = 1'b0;
    #1;
    check("rst_mode_a", mode_a, 3'b100);
    check("rst_value_a", val_a, 5'd0);
    check("rst_ready_a", ra, 2'b00);
    check("rst_gid_a", gid_a, 3'd0);
    check("rst_busy_a", busy_a, 1'b1);
    check("rst_mode_b", mode_b, 3'b100);
    check("rst_busy_b", busy_b, 1'b1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Start-up with no requests, then idle NOPs.
    repeat (4) step();

    // Both requesters on A continuously; single requester on B with gap 3.
    rv[0][0] = 1'b1; rm[0][0] = 3'b000; rx[0][0] = 5'd3;
    rv[0][1] = 1'b1; rm[0][1] = 3'b000; rx[0][1] = 5'd7;
    rv[1][0] = 1'b1; rm[1][0] = 3'b000; rx[1][0] = 5'd5;
    repeat (10) step();

    // Withdrawal: req1 on B raises during the gap and drops before being ready.
    n = 0;
    while (!e_cmd[1] && n < 8) begin step(); n++; end
    check("gap_cmd_seen", e_cmd[1], 1'b1);
    rv[1][1] = 1'b1; rm[1][1] = 3'b001; rx[1][1] = 5'd17;
    step();
    rv[1][1] = 1'b0;
    repeat (6) step();

    // Reset while a command sits on A's bus: outputs drop without a clock edge.
    check("pre_rst_cmd", e_cmd[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_mode_a", mode_a, 3'b100);
    check("async_mode_b", mode_b, 3'b100);
    check("async_ready_a", ra, 2'b00);
    check("async_busy_a", busy_a, 1'b1);
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    repeat (8) step();

    // Randomised traffic including withdrawals.
    rand_on = 1'b1;
    repeat (400) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
